// File: rtl/four_bit_seq_multplr.sv
// Sequential shift-and-add multiplier feeding the display's product digits.
// One operand pair per start request, WIDTH iterations per product; the result
// register only changes on entry to DONE so the display never sees partial sums.
module four_bit_seq_multplr #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]   product_q, product_d;

   logic            accept;
   logic [PW-1:0]   acc_sum;

   // Start is only honoured while idle or in the single DONE cycle.
   assign accept  = start && (state_q != StCalc);
   assign acc_sum = mplr_q[0] ? (acc_q + (mcand_q << cnt_q)) : acc_q;

   // State and datapath registers; clr abandons any operation in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StCalc;
         StCalc: if (cnt_q == CntLast) state_d = StDone;
         StDone: state_d = accept ? StCalc : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: load on accept, one partial product per CALC cycle.
   always_comb begin
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      if (state_q == StCalc) begin
         acc_d  = acc_sum;
         mplr_d = mplr_q >> 1;
         cnt_d  = cnt_q + 1'b1;
         // Final iteration: publish the completed sum, never a partial one.
         if (cnt_q == CntLast) product_d = acc_sum;
      end else if (accept) begin
         mcand_d = PW'(a);
         mplr_d  = b;
         acc_d   = '0;
         cnt_d   = '0;
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      busy    = (state_q == StCalc);
      done    = (state_q == StDone);
      product = product_q;
   end

endmodule

// File: tb/tb_four_bit_seq_multplr.sv
// Self-checking bench for four_bit_seq_multplr: vector table, exhaustive and
// random products against plain a*b, plus multi-cycle corner sequences.
module tb_four_bit_seq_multplr;

   localparam int unsigned WIDTH = 4;

   logic         clk;
   logic         clr;
   logic         start;
   logic [3:0]   a;
   logic [3:0]   b;
   logic         busy;
   logic         done;
   logic [7:0]   product;

   int n_pass;
   int n_total;

   typedef struct {
      logic [3:0] va;
      logic [3:0] vb;
      logic [7:0] exp;
   } vec_t;

   four_bit_seq_multplr #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference: product is simply a*b, visible WIDTH cycles after the accept edge.
   function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
      return 8'(x) * 8'(y);
   endfunction

   // One full operation; 'full' adds latency, pulse-width and hold checks.
   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input string tag,
                        input bit full);
      int          busy_n;
      bit          got_done;
      logic [7:0]  exp;
      exp = ref_mul(ta, tb_v);
      @(negedge clk);
      a = ta;
      b = tb_v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy_n = 0;
      got_done = 1'b0;
      for (int i = 0; i < 3 * WIDTH && !got_done; i++) begin
         if (done) got_done = 1'b1;
         else begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
         end
      end
      check({tag, " product"}, product, exp);
      if (full) begin
         check({tag, " done seen"}, got_done, 1);
         check({tag, " busy cycles"}, busy_n, WIDTH);
         @(posedge clk);
         #1;
         check({tag, " done single"}, done, 0);
         check({tag, " product held"}, product, exp);
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   done_n;
      int   last_done;
      int   interval_bad;
      n_pass  = 0;
      n_total = 0;
      vecs[0] = '{4'h7, 4'h3, 8'h15};
      vecs[1] = '{4'hF, 4'hF, 8'hE1};
      vecs[2] = '{4'h0, 4'h9, 8'h00};
      vecs[3] = '{4'h9, 4'h0, 8'h00};
      vecs[4] = '{4'h1, 4'hF, 8'h0F};
      vecs[5] = '{4'h5, 4'h5, 8'h19};
      vecs[6] = '{4'h6, 4'h7, 8'h2A};

      // Reset with start asserted must keep everything idle.
      clr = 1'b0;
      start = 1'b1;
      a = 4'hF;
      b = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset product", product, 8'h00);
      @(negedge clk);
      start = 1'b0;
      clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle busy", busy, 0);
      check("idle done", done, 0);
      check("idle product", product, 8'h00);

      // Vector table, including the extremes.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].exp !== ref_mul(vecs[i].va, vecs[i].vb))
            $display("note: table entry %0d disagrees with model", i);
         do_op(vecs[i].va, vecs[i].vb, $sformatf("vec%0d", i), 1'b1);
      end

      // Exhaustive pairs.
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            do_op(4'(x), 4'(y), $sformatf("exh %0d*%0d", x, y), 1'b0);

      // Random pairs with full timing checks.
      for (int i = 0; i < 30; i++)
         do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               $sformatf("rnd%0d", i), 1'b1);

      // Start during CALC is ignored; operand changes mid-CALC have no effect.
      @(negedge clk);
      a = 4'h5;
      b = 4'h5;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 4'h2;
      b = 4'h2;
      done_n = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            start = 1'b0;
            a = 4'hF;
            b = 4'hA;
         end
         if (done) begin
            done_n++;
            check("ignore product", product, 8'h19);
         end
         @(posedge clk);
         #1;
      end
      check("ignore done count", done_n, 1);
      check("ignore product held", product, 8'h19);

      // Start held high: back-to-back products every WIDTH+1 cycles.
      @(negedge clk);
      a = 4'h3;
      b = 4'h4;
      start = 1'b1;
      done_n = 0;
      last_done = -1;
      interval_bad = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (last_done >= 0 && (i - last_done) != WIDTH + 1) interval_bad++;
            last_done = i;
            done_n++;
            check("b2b product", product, 8'h0C);
         end
      end
      check("b2b done count", done_n, 3);
      check("b2b interval errors", interval_bad, 0);
      start = 1'b0;
      for (int i = 0; i < 12 && (busy || done); i++) begin
         @(posedge clk);
         #1;
      end
      check("b2b drained", {busy, done}, 2'b00);

      // Asynchronous clear in the 3rd CALC cycle of 6*7.
      @(negedge clk);
      a = 4'h6;
      b = 4'h7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      clr = 1'b0;
      #1;
      check("aclr busy", busy, 0);
      check("aclr done", done, 0);
      check("aclr product", product, 8'h00);
      @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) done_n++;
      end
      check("aclr no done", done_n, 0);
      check("aclr product stays", product, 8'h00);
      do_op(4'h6, 4'h7, "after aclr", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
